// File: rtl/axil_csr_pkg.sv
// Shared definitions for the AXI4-Lite CSR responder: register offsets,
// response codes, register-select codes and FSM state types.
package axil_csr_pkg;

  localparam logic [7:0] OFF_ID       = 8'h00;
  localparam logic [7:0] OFF_SCRATCH  = 8'h04;
  localparam logic [7:0] OFF_CTRL     = 8'h08;
  localparam logic [7:0] OFF_STATUS   = 8'h0C;
  localparam logic [7:0] OFF_DOORBELL = 8'h10;
  localparam logic [7:0] OFF_DBCOUNT  = 8'h14;
  localparam logic [7:0] OFF_WRCOUNT  = 8'h18;
  localparam logic [7:0] OFF_RDCOUNT  = 8'h1C;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [3:0] {
    SEL_ID,
    SEL_SCRATCH,
    SEL_CTRL,
    SEL_STATUS,
    SEL_DOORBELL,
    SEL_DBCOUNT,
    SEL_WRCOUNT,
    SEL_RDCOUNT,
    SEL_NONE
  } reg_sel_e;

  typedef enum logic {W_IDLE, W_RESP} wr_state_e;
  typedef enum logic {R_IDLE, R_RESP} rd_state_e;

endpackage

// File: rtl/axil_csr_decode.sv
// Combinational offset decoder and read mux shared by the read path and the
// write commit. AXIL_CSR_STATS_EN adds the WR_COUNT/RD_COUNT offsets.
module axil_csr_decode
  import axil_csr_pkg::*;
#(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [31:0] ID_VALUE   = 32'h5649_4F31
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           scratch,
  input  logic [31:0]           ctrl,
  input  logic [31:0]           status,
  input  logic [31:0]           db_count,
`ifdef AXIL_CSR_STATS_EN
  input  logic [31:0]           wr_count,
  input  logic [31:0]           rd_count,
`endif
  output logic [3:0]            sel,
  output logic                  hit,
  output logic [31:0]           rdata
);

  logic upper_zero;

  // Only bits [7:2] select a register; anything above must be zero.
  assign upper_zero = ((addr >> 8) == '0);

  always_comb begin
    sel   = SEL_NONE;
    hit   = 1'b0;
    rdata = '0;
    if (upper_zero) begin
      case ({addr[7:2], 2'b00})
        OFF_ID:       begin sel = SEL_ID;       hit = 1'b1; rdata = ID_VALUE; end
        OFF_SCRATCH:  begin sel = SEL_SCRATCH;  hit = 1'b1; rdata = scratch;  end
        OFF_CTRL:     begin sel = SEL_CTRL;     hit = 1'b1; rdata = ctrl;     end
        OFF_STATUS:   begin sel = SEL_STATUS;   hit = 1'b1; rdata = status;   end
        OFF_DOORBELL: begin sel = SEL_DOORBELL; hit = 1'b1; rdata = '0;       end
        OFF_DBCOUNT:  begin sel = SEL_DBCOUNT;  hit = 1'b1; rdata = db_count; end
`ifdef AXIL_CSR_STATS_EN
        OFF_WRCOUNT:  begin sel = SEL_WRCOUNT;  hit = 1'b1; rdata = wr_count; end
        OFF_RDCOUNT:  begin sel = SEL_RDCOUNT;  hit = 1'b1; rdata = rd_count; end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/axil_csr_responder.sv
// AXI4-Lite CSR slave: ID/scratch/control/status/doorbell map with independent
// read and write FSMs. Define AXIL_CSR_STATS_EN for WR_COUNT/RD_COUNT counters.
module axil_csr_responder
  import axil_csr_pkg::*;
#(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [31:0] ID_VALUE   = 32'h5649_4F31,
  parameter logic [31:0] CTRL_RESET = 32'h0
) (
  input  logic                  ACLK,
  input  logic                  RESET,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [31:0]           s_axil_wdata,
  input  logic [3:0]            s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [31:0]           s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic [31:0]           ctrl_out,
  input  logic [31:0]           status_in,
  output logic                  doorbell_pulse,
  output logic [31:0]           doorbell_data
);

  wr_state_e wstate, wstate_d;
  rd_state_e rstate, rstate_d;

  logic                  aw_got, w_got;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;
  logic                  aw_hs, w_hs, ar_hs, commit;

  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_data;
  logic [3:0]            wr_strb;

  logic [31:0] scratch_q, db_count_q;
  logic [3:0]  wr_sel, unused_rd_sel;
  logic        wr_hit, rd_hit;
  logic [31:0] unused_wr_rdata, rd_mux;
`ifdef AXIL_CSR_STATS_EN
  logic [31:0] wr_count_q, rd_count_q;
`endif

  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{strb[i]}};
    return m;
  endfunction

  function automatic logic [31:0] strb_merge(input logic [31:0] old, input logic [31:0] data,
                                             input logic [3:0] strb);
    return (old & ~strb_mask(strb)) | (data & strb_mask(strb));
  endfunction

  // A channel handshaking in the commit cycle is used directly, not via its capture register.
  assign wr_addr = aw_got ? awaddr_q : s_axil_awaddr;
  assign wr_data = w_got  ? wdata_q  : s_axil_wdata;
  assign wr_strb = w_got  ? wstrb_q  : s_axil_wstrb;

  axil_csr_decode #(.ADDR_WIDTH(ADDR_WIDTH), .ID_VALUE(ID_VALUE)) u_wr_dec (
    .addr     (wr_addr),
    .scratch  (scratch_q),
    .ctrl     (ctrl_out),
    .status   (status_in),
    .db_count (db_count_q),
`ifdef AXIL_CSR_STATS_EN
    .wr_count (wr_count_q),
    .rd_count (rd_count_q),
`endif
    .sel      (wr_sel),
    .hit      (wr_hit),
    .rdata    (unused_wr_rdata)
  );

  axil_csr_decode #(.ADDR_WIDTH(ADDR_WIDTH), .ID_VALUE(ID_VALUE)) u_rd_dec (
    .addr     (s_axil_araddr),
    .scratch  (scratch_q),
    .ctrl     (ctrl_out),
    .status   (status_in),
    .db_count (db_count_q),
`ifdef AXIL_CSR_STATS_EN
    .wr_count (wr_count_q),
    .rd_count (rd_count_q),
`endif
    .sel      (unused_rd_sel),
    .hit      (rd_hit),
    .rdata    (rd_mux)
  );

  always_comb begin
    wstate_d       = wstate;
    s_axil_awready = 1'b0;
    s_axil_wready  = 1'b0;
    s_axil_bvalid  = 1'b0;
    aw_hs          = 1'b0;
    w_hs           = 1'b0;
    commit         = 1'b0;
    case (wstate)
      W_IDLE: begin
        s_axil_awready = !RESET && !aw_got;
        s_axil_wready  = !RESET && !w_got;
        aw_hs          = s_axil_awready && s_axil_awvalid;
        w_hs           = s_axil_wready && s_axil_wvalid;
        if ((aw_got || aw_hs) && (w_got || w_hs)) begin
          commit   = 1'b1;
          wstate_d = W_RESP;
        end
      end
      W_RESP: begin
        s_axil_bvalid = 1'b1;
        if (s_axil_bready) wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (RESET) begin
      wstate         <= W_IDLE;
      aw_got         <= 1'b0;
      w_got          <= 1'b0;
      s_axil_bresp   <= RESP_OKAY;
      scratch_q      <= '0;
      ctrl_out       <= CTRL_RESET;
      db_count_q     <= '0;
      doorbell_pulse <= 1'b0;
      doorbell_data  <= '0;
`ifdef AXIL_CSR_STATS_EN
      wr_count_q     <= '0;
`endif
    end else begin
      wstate         <= wstate_d;
      doorbell_pulse <= 1'b0;
      if (aw_hs) begin
        aw_got   <= 1'b1;
        awaddr_q <= s_axil_awaddr;
      end
      if (w_hs) begin
        w_got   <= 1'b1;
        wdata_q <= s_axil_wdata;
        wstrb_q <= s_axil_wstrb;
      end
      if (commit) begin
        aw_got       <= 1'b0;
        w_got        <= 1'b0;
        s_axil_bresp <= wr_hit ? RESP_OKAY : RESP_DECERR;
`ifdef AXIL_CSR_STATS_EN
        wr_count_q   <= wr_count_q + 32'd1;
`endif
        if (wr_sel == SEL_SCRATCH) scratch_q <= strb_merge(scratch_q, wr_data, wr_strb);
        if (wr_sel == SEL_CTRL)    ctrl_out  <= strb_merge(ctrl_out, wr_data, wr_strb);
        // Doorbell fires on any strobe pattern; masked bytes are delivered as zero.
        if (wr_sel == SEL_DOORBELL) begin
          doorbell_pulse <= 1'b1;
          doorbell_data  <= wr_data & strb_mask(wr_strb);
          db_count_q     <= db_count_q + 32'd1;
        end
      end
    end
  end

  always_comb begin
    rstate_d       = rstate;
    s_axil_arready = 1'b0;
    s_axil_rvalid  = 1'b0;
    ar_hs          = 1'b0;
    case (rstate)
      R_IDLE: begin
        s_axil_arready = !RESET;
        ar_hs          = s_axil_arready && s_axil_arvalid;
        if (ar_hs) rstate_d = R_RESP;
      end
      R_RESP: begin
        s_axil_rvalid = 1'b1;
        if (s_axil_rready) rstate_d = R_IDLE;
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // Read data is captured from pre-edge register values, so a same-cycle write is not seen.
  always_ff @(posedge ACLK) begin
    if (RESET) begin
      rstate       <= R_IDLE;
      s_axil_rdata <= '0;
      s_axil_rresp <= RESP_OKAY;
`ifdef AXIL_CSR_STATS_EN
      rd_count_q   <= '0;
`endif
    end else begin
      rstate <= rstate_d;
      if (ar_hs) begin
        s_axil_rdata <= rd_mux;
        s_axil_rresp <= rd_hit ? RESP_OKAY : RESP_DECERR;
`ifdef AXIL_CSR_STATS_EN
        rd_count_q   <= rd_count_q + 32'd1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_axil_csr_responder.sv
// Scoreboard bench for axil_csr_responder; honours AXIL_CSR_STATS_EN when defined.
module tb_axil_csr_responder;
  import axil_csr_pkg::*;

  logic        ACLK, RESET;
  logic [11:0] s_axil_awaddr, s_axil_araddr;
  logic        s_axil_awvalid, s_axil_awready;
  logic [31:0] s_axil_wdata;
  logic [3:0]  s_axil_wstrb;
  logic        s_axil_wvalid, s_axil_wready;
  logic [1:0]  s_axil_bresp, s_axil_rresp;
  logic        s_axil_bvalid, s_axil_bready;
  logic        s_axil_arvalid, s_axil_arready;
  logic [31:0] s_axil_rdata;
  logic        s_axil_rvalid, s_axil_rready;
  logic [31:0] ctrl_out, status_in, doorbell_data;
  logic        doorbell_pulse;

  int n_cmp = 0;
  int n_bad = 0;
  int m_wr = 0;
  int m_rd = 0;
  int pulse_cnt = 0;

  logic [1:0]  exp_b[$];
  logic [31:0] exp_rd[$];
  logic [1:0]  exp_rr[$];

  axil_csr_responder dut (
    .ACLK           (ACLK),
    .RESET          (RESET),
    .s_axil_awaddr  (s_axil_awaddr),
    .s_axil_awvalid (s_axil_awvalid),
    .s_axil_awready (s_axil_awready),
    .s_axil_wdata   (s_axil_wdata),
    .s_axil_wstrb   (s_axil_wstrb),
    .s_axil_wvalid  (s_axil_wvalid),
    .s_axil_wready  (s_axil_wready),
    .s_axil_bresp   (s_axil_bresp),
    .s_axil_bvalid  (s_axil_bvalid),
    .s_axil_bready  (s_axil_bready),
    .s_axil_araddr  (s_axil_araddr),
    .s_axil_arvalid (s_axil_arvalid),
    .s_axil_arready (s_axil_arready),
    .s_axil_rdata   (s_axil_rdata),
    .s_axil_rresp   (s_axil_rresp),
    .s_axil_rvalid  (s_axil_rvalid),
    .s_axil_rready  (s_axil_rready),
    .ctrl_out       (ctrl_out),
    .status_in      (status_in),
    .doorbell_pulse (doorbell_pulse),
    .doorbell_data  (doorbell_data)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  always @(negedge ACLK) if (doorbell_pulse === 1'b1) pulse_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic collect_b();
    int n = 0;
    while (s_axil_bvalid !== 1'b1 && n < 20) begin @(negedge ACLK); n++; end
    chk("bvalid_seen", 32'(s_axil_bvalid), 1);
    if (exp_b.size() > 0) chk("bresp", 32'(s_axil_bresp), 32'(exp_b.pop_front()));
  endtask

  task automatic collect_r();
    int n = 0;
    while (s_axil_rvalid !== 1'b1 && n < 20) begin @(negedge ACLK); n++; end
    chk("rvalid_seen", 32'(s_axil_rvalid), 1);
    if (exp_rd.size() > 0) begin
      chk("rdata", s_axil_rdata, exp_rd.pop_front());
      chk("rresp", 32'(s_axil_rresp), 32'(exp_rr.pop_front()));
    end
  endtask

  // W is presented w_lead cycles before AW; called and returns at posedge+1.
  task automatic axil_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int w_lead, input logic [1:0] exp_resp, input bit chk_lat);
    bit aw_done = 0;
    bit w_done = 0;
    int cyc = 0;
    exp_b.push_back(exp_resp);
    s_axil_wdata  = data;
    s_axil_wstrb  = strb;
    s_axil_wvalid = 1'b1;
    while (!(aw_done && w_done) && cyc < 40) begin
      if (cyc == w_lead) begin
        s_axil_awaddr  = addr;
        s_axil_awvalid = 1'b1;
      end
      @(negedge ACLK);
      if (s_axil_awvalid && s_axil_awready) aw_done = 1;
      if (s_axil_wvalid && s_axil_wready) w_done = 1;
      @(posedge ACLK); #1;
      if (aw_done) s_axil_awvalid = 1'b0;
      if (w_done) s_axil_wvalid = 1'b0;
      cyc++;
    end
    chk("aw_w_accept", 32'(aw_done && w_done), 1);
    m_wr++;
    @(negedge ACLK);
    if (chk_lat) chk("b_latency", 32'(s_axil_bvalid), 1);
    collect_b();
    @(posedge ACLK); #1;
  endtask

  task automatic axil_read(input logic [11:0] addr, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp);
    bit hs = 0;
    int cyc = 0;
    exp_rd.push_back(exp_data);
    exp_rr.push_back(exp_resp);
    s_axil_araddr  = addr;
    s_axil_arvalid = 1'b1;
    while (!hs && cyc < 40) begin
      @(negedge ACLK);
      hs = s_axil_arready;
      @(posedge ACLK); #1;
      cyc++;
    end
    s_axil_arvalid = 1'b0;
    chk("ar_accept", 32'(hs), 1);
    m_rd++;
    @(negedge ACLK);
    chk("r_latency", 32'(s_axil_rvalid), 1);
    collect_r();
    @(posedge ACLK); #1;
  endtask

  initial begin
    int bad;
    int base;
    RESET = 1'b1;
    s_axil_awaddr = '0; s_axil_awvalid = 1'b0;
    s_axil_wdata = '0; s_axil_wstrb = '0; s_axil_wvalid = 1'b0;
    s_axil_bready = 1'b1;
    s_axil_araddr = '0; s_axil_arvalid = 1'b0;
    s_axil_rready = 1'b1;
    status_in = '0;

    repeat (3) @(posedge ACLK);
    #1;
    @(negedge ACLK);
    chk("rst_awready", 32'(s_axil_awready), 0);
    chk("rst_wready", 32'(s_axil_wready), 0);
    chk("rst_arready", 32'(s_axil_arready), 0);
    chk("rst_bvalid", 32'(s_axil_bvalid), 0);
    chk("rst_rvalid", 32'(s_axil_rvalid), 0);
    chk("rst_pulse", 32'(doorbell_pulse), 0);
    chk("rst_ctrl", ctrl_out, 32'h0);
    chk("rst_db_data", doorbell_data, 32'h0);
    chk("rst_rdata", s_axil_rdata, 32'h0);
    chk("rst_bresp", 32'(s_axil_bresp), 0);
    @(posedge ACLK); #1;
    RESET = 1'b0;
    @(negedge ACLK);
    chk("post_rst_awready", 32'(s_axil_awready), 1);
    chk("post_rst_wready", 32'(s_axil_wready), 1);
    chk("post_rst_arready", 32'(s_axil_arready), 1);
    @(posedge ACLK); #1;

    axil_read(12'h000, 32'h5649_4F31, RESP_OKAY);

    axil_write(12'h004, 32'hA5A5_A5A5, 4'b0101, 3, RESP_OKAY, 1);
    axil_read(12'h004, 32'h00A5_00A5, RESP_OKAY);

    axil_write(12'h008, 32'hDEAD_BEEF, 4'hF, 0, RESP_OKAY, 1);
    chk("ctrl_full", ctrl_out, 32'hDEAD_BEEF);
    axil_write(12'h008, 32'h1122_3344, 4'b1000, 1, RESP_OKAY, 1);
    chk("ctrl_byte3", ctrl_out, 32'h11AD_BEEF);
    axil_read(12'h008, 32'h11AD_BEEF, RESP_OKAY);

    status_in = 32'hCAFE_0001;
    axil_read(12'h00C, 32'hCAFE_0001, RESP_OKAY);

    axil_write(12'h000, 32'hFFFF_FFFF, 4'hF, 0, RESP_OKAY, 1);
    axil_read(12'h000, 32'h5649_4F31, RESP_OKAY);
    axil_write(12'h014, 32'h0000_0099, 4'hF, 0, RESP_OKAY, 1);

    base = pulse_cnt;
    for (int i = 0; i < 3; i++) axil_write(12'h010, 32'h0000_1234, 4'hF, i, RESP_OKAY, 1);
    chk("db_pulses", 32'(pulse_cnt - base), 3);
    chk("db_data", doorbell_data, 32'h0000_1234);
    axil_read(12'h014, 32'd3, RESP_OKAY);
    axil_read(12'h010, 32'h0, RESP_OKAY);
    axil_write(12'h010, 32'hAABB_CCDD, 4'b0001, 0, RESP_OKAY, 1);
    chk("db_data_masked", doorbell_data, 32'h0000_00DD);
    axil_read(12'h014, 32'd4, RESP_OKAY);

    axil_read(12'h040, 32'h0, RESP_DECERR);
    axil_write(12'h040, 32'hFFFF_FFFF, 4'hF, 0, RESP_DECERR, 1);
    axil_read(12'h004, 32'h00A5_00A5, RESP_OKAY);
    axil_read(12'h104, 32'h0, RESP_DECERR);
    axil_write(12'h108, 32'h0, 4'hF, 0, RESP_DECERR, 1);
    chk("ctrl_after_decerr", ctrl_out, 32'h11AD_BEEF);

`ifdef AXIL_CSR_STATS_EN
    axil_read(12'h018, m_wr, RESP_OKAY);
    axil_read(12'h01C, m_rd, RESP_OKAY);
`else
    axil_read(12'h018, 32'h0, RESP_DECERR);
    axil_read(12'h01C, 32'h0, RESP_DECERR);
`endif

    // Stalled responses with a same-cycle write and read of SCRATCH.
    s_axil_bready = 1'b0;
    s_axil_rready = 1'b0;
    exp_b.push_back(RESP_OKAY);
    exp_rd.push_back(32'h00A5_00A5);
    exp_rr.push_back(RESP_OKAY);
    s_axil_awaddr = 12'h004; s_axil_awvalid = 1'b1;
    s_axil_wdata = 32'h5555_0000; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
    s_axil_araddr = 12'h004; s_axil_arvalid = 1'b1;
    @(negedge ACLK);
    chk("stall_aw_w_hs", 32'(s_axil_awready && s_axil_wready), 1);
    chk("stall_ar_hs", 32'(s_axil_arready), 1);
    @(posedge ACLK); #1;
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_arvalid = 1'b0;
    m_wr++; m_rd++;
    @(negedge ACLK);
    collect_b();
    collect_r();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge ACLK); #1;
      @(negedge ACLK);
      if (s_axil_bvalid !== 1'b1 || s_axil_rvalid !== 1'b1 || s_axil_bresp !== RESP_OKAY ||
          s_axil_rdata !== 32'h00A5_00A5 || s_axil_rresp !== RESP_OKAY ||
          (s_axil_awready | s_axil_wready | s_axil_arready) !== 1'b0)
        bad++;
    end
    chk("stall_hold_bad_cycles", 32'(bad), 0);
    @(posedge ACLK); #1;
    s_axil_bready = 1'b1;
    s_axil_rready = 1'b1;
    @(posedge ACLK); #1;
    @(negedge ACLK);
    chk("stall_bvalid_done", 32'(s_axil_bvalid), 0);
    chk("stall_rvalid_done", 32'(s_axil_rvalid), 0);
    @(posedge ACLK); #1;
    axil_read(12'h004, 32'h5555_0000, RESP_OKAY);

    // Reset while a write response is pending.
    s_axil_bready = 1'b0;
    axil_write(12'h008, 32'h0000_0077, 4'hF, 0, RESP_OKAY, 1);
    chk("ctrl_before_abort", ctrl_out, 32'h0000_0077);
    RESET = 1'b1;
    @(posedge ACLK); #1;
    RESET = 1'b0;
    @(negedge ACLK);
    chk("abort_bvalid", 32'(s_axil_bvalid), 0);
    chk("abort_ctrl", ctrl_out, 32'h0);
    chk("abort_db_data", doorbell_data, 32'h0);
    s_axil_bready = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      if (s_axil_bvalid !== 1'b0) bad++;
    end
    chk("abort_no_bresp", 32'(bad), 0);
    @(posedge ACLK); #1;
    m_wr = 0;
    m_rd = 0;
`ifdef AXIL_CSR_STATS_EN
    axil_read(12'h018, 32'h0, RESP_OKAY);
`else
    axil_read(12'h018, 32'h0, RESP_DECERR);
`endif
    axil_read(12'h004, 32'h0, RESP_OKAY);
    axil_read(12'h014, 32'h0, RESP_OKAY);
    axil_read(12'h000, 32'h5649_4F31, RESP_OKAY);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
